// File: rtl/params_pkg.sv
// Shared types and trap codes for the data-memory access path.
// The state enum is also used by the bench to decode dbg_state.
package params_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } dmem_state_t;

  localparam logic [30:0] TRAP_CODE_LOAD_ADDR_MISALIGNED  = 31'd4;
  localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT     = 31'd5;
  localparam logic [30:0] TRAP_CODE_STORE_ADDR_MISALIGNED = 31'd6;
  localparam logic [30:0] TRAP_CODE_STORE_ACCESS_FAULT    = 31'd7;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Byte ops are always aligned; halfwords need bit 0 clear, words both bits.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lsb2);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = lsb2[0];
      MEM_LW, MEM_SW:          mis = |lsb2;
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational byte-strobe and lane-replicated store data generation.
// Loads produce zero strobes and zero data.
module store_align
  import params_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  lsb2,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane
);

  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = 32'h0;
    case (op)
      MEM_SB: begin
        wstrb      = 4'b0001 << lsb2;
        wdata_lane = {4{wdata[7:0]}};
      end
      MEM_SH: begin
        wstrb      = 4'b0011 << lsb2;
        wdata_lane = {2{wdata[15:0]}};
      end
      MEM_SW: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store sequencer between the MEM stage and the data bus: alignment check,
// valid/ready request, response capture and trap reporting to the load formatter.
module dmem_access_unit
  import params_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  mem_op_t     mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rsp_valid,
  output mem_op_t     rsp_mem_op,
  output logic [1:0]  rsp_addr_lsb2,
  output logic [31:0] rsp_rdata_raw,
  output logic [3:0]  rsp_wmask,
  output logic        rsp_trap_valid,
  output logic [30:0] rsp_trap_mcause,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rsp_err,
  output logic [2:0]  dbg_state
);

  // Bus handshake: a request transfers on a rising edge where dmem_req_valid
  // and dmem_req_ready are both high; while valid is high and ready is low,
  // address, we, wstrb and wdata stay stable. dmem_rsp_valid is only looked at
  // in WAIT and DRAIN (one outstanding access).

  dmem_state_t state_q, state_d;
  mem_op_t     op_q;
  logic [1:0]  lsb2_q;
  logic        trap_q;
  logic        start, misaligned;
  logic [3:0]  wstrb_nx;
  logic [31:0] wdata_nx;

  store_align u_store_align (
    .op         (mem_op),
    .lsb2       (mem_addr[1:0]),
    .wdata      (mem_wdata),
    .wstrb      (wstrb_nx),
    .wdata_lane (wdata_nx)
  );

  assign start      = (state_q == IDLE) && mem_valid && (mem_op != MEM_NONE) && !flush;
  assign misaligned = is_misaligned(mem_op, mem_addr[1:0]);
  assign stall      = start || (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
  assign dbg_state  = state_q;

  // DONE is the single result cycle; a flush landing on it squashes the result.
  assign rsp_valid      = (state_q == DONE) && !flush;
  assign rsp_trap_valid = rsp_valid && trap_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = misaligned ? DONE : REQ;
      REQ: begin
        if (dmem_req_ready) state_d = flush ? DRAIN : WAIT;
        else if (flush)     state_d = IDLE;
      end
      WAIT: begin
        if (dmem_rsp_valid) state_d = flush ? IDLE : DONE;
        else if (flush)     state_d = DRAIN;
      end
      DONE:  state_d = IDLE;
      DRAIN: if (dmem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      op_q            <= MEM_NONE;
      lsb2_q          <= 2'b00;
      trap_q          <= 1'b0;
      dmem_req_valid  <= 1'b0;
      dmem_addr       <= 32'h0;
      dmem_we         <= 1'b0;
      dmem_wstrb      <= 4'b0000;
      dmem_wdata      <= 32'h0;
      rsp_mem_op      <= MEM_NONE;
      rsp_addr_lsb2   <= 2'b00;
      rsp_rdata_raw   <= 32'h0;
      rsp_wmask       <= 4'b0000;
      rsp_trap_mcause <= 31'h0;
    end else begin
      state_q        <= state_d;
      dmem_req_valid <= (state_d == REQ);

      if (start) begin
        op_q   <= mem_op;
        lsb2_q <= mem_addr[1:0];
        if (!misaligned) begin
          dmem_addr  <= {mem_addr[31:2], 2'b00};
          dmem_we    <= is_store(mem_op);
          dmem_wstrb <= wstrb_nx;
          dmem_wdata <= wdata_nx;
        end
      end

      if (start && misaligned) begin
        rsp_mem_op      <= mem_op;
        rsp_addr_lsb2   <= mem_addr[1:0];
        rsp_rdata_raw   <= 32'h0;
        rsp_wmask       <= 4'b0000;
        trap_q          <= 1'b1;
        rsp_trap_mcause <= is_store(mem_op) ? TRAP_CODE_STORE_ADDR_MISALIGNED
                                            : TRAP_CODE_LOAD_ADDR_MISALIGNED;
      end else if ((state_q == WAIT) && (state_d == DONE)) begin
        rsp_mem_op    <= op_q;
        rsp_addr_lsb2 <= lsb2_q;
        if (dmem_rsp_err) begin
          rsp_rdata_raw   <= 32'h0;
          rsp_wmask       <= 4'b0000;
          trap_q          <= 1'b1;
          rsp_trap_mcause <= is_store(op_q) ? TRAP_CODE_STORE_ACCESS_FAULT
                                            : TRAP_CODE_LOAD_ACCESS_FAULT;
        end else begin
          rsp_rdata_raw   <= is_store(op_q) ? 32'h0 : (dmem_rdata >> {lsb2_q, 3'b000});
          rsp_wmask       <= dmem_wstrb;
          trap_q          <= 1'b0;
          rsp_trap_mcause <= 31'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a bus responder model, a request
// scoreboard and a response scoreboard fed by expected-value queues.
module tb_dmem_access_unit;
  import params_pkg::*;

  logic        clk, rst_n;
  logic        mem_valid;
  mem_op_t     mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        flush;
  logic        stall;
  logic        rsp_valid;
  mem_op_t     rsp_mem_op;
  logic [1:0]  rsp_addr_lsb2;
  logic [31:0] rsp_rdata_raw;
  logic [3:0]  rsp_wmask;
  logic        rsp_trap_valid;
  logic [30:0] rsp_trap_mcause;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        dmem_rsp_err;
  logic [2:0]  dbg_state;

  dmem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_mem_op(rsp_mem_op), .rsp_addr_lsb2(rsp_addr_lsb2),
    .rsp_rdata_raw(rsp_rdata_raw), .rsp_wmask(rsp_wmask),
    .rsp_trap_valid(rsp_trap_valid), .rsp_trap_mcause(rsp_trap_mcause),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .dmem_rsp_err(dmem_rsp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [73:0] exp_q[$];
  logic [68:0] bus_q[$];

  int          cfg_ready_delay = 0;
  int          cfg_rsp_delay   = 0;
  logic [31:0] cfg_rdata       = 32'h0;
  logic        cfg_err         = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] rsp_pack(input mem_op_t op, input logic [1:0] lsb,
                                           input logic [31:0] rd, input logic [3:0] wm,
                                           input logic trap, input logic [30:0] mc);
    return {4'(op), lsb, rd, wm, trap, mc};
  endfunction

  function automatic logic [68:0] bus_pack(input logic [31:0] a, input logic we,
                                           input logic [3:0] st, input logic [31:0] wd);
    return {a, we, st, wd};
  endfunction

  // bus responder plus request scoreboard
  int ready_cnt   = 0;
  int rsp_cnt     = 0;
  bit rsp_pending = 0;
  initial begin
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'h0;
    dmem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      dmem_rsp_err   = 1'b0;
      dmem_rdata     = 32'h0;
      dmem_req_ready = 1'b0;
      if (rsp_pending) begin
        if (rsp_cnt >= cfg_rsp_delay) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata     = cfg_rdata;
          dmem_rsp_err   = cfg_err;
          rsp_pending    = 0;
        end else rsp_cnt++;
      end
      if (rst_n && dmem_req_valid) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h required no request", dmem_addr);
        end else begin
          chk("bus_req", bus_pack(dmem_addr, dmem_we, dmem_wstrb, dmem_wdata), bus_q[0]);
          if (ready_cnt >= cfg_ready_delay) begin
            dmem_req_ready = 1'b1;
            void'(bus_q.pop_front());
            rsp_pending = 1;
            rsp_cnt     = 0;
            ready_cnt   = 0;
          end else ready_cnt++;
        end
      end else ready_cnt = 0;
    end
  end

  // response scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got op %0d trap %b required no response", rsp_mem_op, rsp_trap_valid);
      end else begin
        chk("rsp", rsp_pack(rsp_mem_op, rsp_addr_lsb2, rsp_rdata_raw, rsp_wmask,
                            rsp_trap_valid, rsp_trap_mcause), exp_q.pop_front());
      end
    end
  end

  // driver: issue one op, hold it while stalled, check stall length
  task automatic do_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input int rdy_d, input int rsp_d, input logic [31:0] rd, input logic err,
                       input bit has_bus, input logic [68:0] exp_bus,
                       input logic [73:0] exp_rsp, input int exp_stall);
    int cycles;
    @(negedge clk);
    cfg_ready_delay = rdy_d;
    cfg_rsp_delay   = rsp_d;
    cfg_rdata       = rd;
    cfg_err         = err;
    if (has_bus) bus_q.push_back(exp_bus);
    exp_q.push_back(exp_rsp);
    mem_valid = 1'b1;
    mem_op    = op;
    mem_addr  = addr;
    mem_wdata = wd;
    #1;
    cycles = 0;
    while (stall && cycles < 60) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 128'(cycles), 128'(exp_stall));
    chk("rsp_valid_on_release", 128'(rsp_valid), 128'(1));
    mem_valid = 1'b0;
    mem_op    = MEM_NONE;
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    bit flushed;
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    mem_op    = MEM_NONE;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ctrl", {stall, dmem_req_valid, rsp_valid, rsp_trap_valid, dmem_we}, 5'b0);
    chk("reset_data", {rsp_rdata_raw, rsp_trap_mcause, rsp_wmask, dmem_wstrb}, 71'h0);
    chk("reset_state", dbg_state, 3'(IDLE));

    // aligned loads, zero-wait
    do_op(MEM_LW, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1, bus_pack(32'h100, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LW, 2'd0, 32'hDEADBEEF, 4'h0, 1'b0, 31'd0), 3);
    do_op(MEM_LB, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0, 1, bus_pack(32'h100, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LB, 2'd3, 32'h00000080, 4'h0, 1'b0, 31'd0), 3);
    // store with ready held low three cycles
    do_op(MEM_SH, 32'h202, 32'h0000ABCD, 3, 0, 32'hFFFFFFFF, 1'b0, 1,
          bus_pack(32'h200, 1'b1, 4'b1100, 32'hABCDABCD),
          rsp_pack(MEM_SH, 2'd2, 32'h0, 4'b1100, 1'b0, 31'd0), 6);
    // misaligned traps, no bus access
    do_op(MEM_LW, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, 0, 69'h0,
          rsp_pack(MEM_LW, 2'd1, 32'h0, 4'h0, 1'b1, 31'd4), 1);
    do_op(MEM_SW, 32'h102, 32'h11223344, 0, 0, 32'h0, 1'b0, 0, 69'h0,
          rsp_pack(MEM_SW, 2'd2, 32'h0, 4'h0, 1'b1, 31'd6), 1);
    // bus error responses
    do_op(MEM_LH, 32'h102, 32'h0, 0, 0, 32'h5555AAAA, 1'b1, 1, bus_pack(32'h100, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LH, 2'd2, 32'h0, 4'h0, 1'b1, 31'd5), 3);
    do_op(MEM_SB, 32'h101, 32'h123456A5, 0, 0, 32'hFFFFFFFF, 1'b0, 1,
          bus_pack(32'h100, 1'b1, 4'b0010, 32'hA5A5A5A5),
          rsp_pack(MEM_SB, 2'd1, 32'h0, 4'b0010, 1'b0, 31'd0), 3);
    do_op(MEM_SW, 32'h10C, 32'h12345678, 0, 2, 32'h0, 1'b1, 1,
          bus_pack(32'h10C, 1'b1, 4'b1111, 32'h12345678),
          rsp_pack(MEM_SW, 2'd0, 32'h0, 4'h0, 1'b1, 31'd7), 5);
    do_op(MEM_LHU, 32'h206, 32'h0, 0, 0, 32'hCAFE1234, 1'b0, 1, bus_pack(32'h204, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LHU, 2'd2, 32'h0000CAFE, 4'h0, 1'b0, 31'd0), 3);
    do_op(MEM_LH, 32'h103, 32'h0, 0, 0, 32'h0, 1'b0, 0, 69'h0,
          rsp_pack(MEM_LH, 2'd3, 32'h0, 4'h0, 1'b1, 31'd4), 1);
    do_op(MEM_SH, 32'h201, 32'h0, 0, 0, 32'h0, 1'b0, 0, 69'h0,
          rsp_pack(MEM_SH, 2'd1, 32'h0, 4'h0, 1'b1, 31'd6), 1);

    // flush while waiting for the response: no result, stall until it drains
    @(negedge clk);
    cfg_ready_delay = 0;
    cfg_rsp_delay   = 4;
    cfg_rdata       = 32'h77777777;
    cfg_err         = 1'b0;
    bus_q.push_back(bus_pack(32'h300, 1'b0, 4'h0, 32'h0));
    mem_valid = 1'b1;
    mem_op    = MEM_LW;
    mem_addr  = 32'h300;
    #1;
    cycles  = 0;
    flushed = 0;
    while (stall && cycles < 60) begin
      if (!flushed && dbg_state == 3'(WAIT)) begin
        flush     = 1'b1;
        mem_valid = 1'b0;
        mem_op    = MEM_NONE;
        flushed   = 1;
      end else flush = 1'b0;
      cycles++;
      @(posedge clk);
      #1;
    end
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_op    = MEM_NONE;
    chk("flush_seen_wait", 128'(flushed), 128'(1));
    chk("flush_stall_cycles", 128'(cycles), 128'(7));
    chk("flush_state_idle", dbg_state, 3'(IDLE));
    @(negedge clk);

    // clean ops after the flush
    do_op(MEM_LBU, 32'h101, 32'h0, 0, 0, 32'h0000AB00, 1'b0, 1, bus_pack(32'h100, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LBU, 2'd1, 32'h000000AB, 4'h0, 1'b0, 31'd0), 3);
    do_op(MEM_LW, 32'h3FC, 32'h0, 1, 1, 32'h01020304, 1'b0, 1, bus_pack(32'h3FC, 1'b0, 4'h0, 32'h0),
          rsp_pack(MEM_LW, 2'd0, 32'h01020304, 4'h0, 1'b0, 31'd0), 5);

    repeat (4) @(negedge clk);
    chk("rsp_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("bus_queue_empty", 128'(bus_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
